// File: rtl/alu_pkg.sv
// Shared definitions for the NES ALU: operation codes and the mode type.
// The CPU control logic imports this package too, so the codes stay in one place.
package alu_pkg;

   // Operation select carried on the 5-bit mode bus
   typedef logic [4:0] alu_mode_t;

   localparam alu_mode_t ALU_ADD = 5'd0;
   localparam alu_mode_t ALU_AND = 5'd1;
   localparam alu_mode_t ALU_OR  = 5'd2;
   localparam alu_mode_t ALU_EOR = 5'd3;
   localparam alu_mode_t ALU_SR  = 5'd4;
   localparam alu_mode_t ALU_SUB = 5'd5;

   // SUB is the only mode that feeds the inverted B operand into the adder
   function automatic logic alu_is_sub(input alu_mode_t mode);
      return (mode == ALU_SUB);
   endfunction

endpackage

// File: rtl/alu_adder8.sv
// Combinational ripple-carry adder with carry-in, carry-out and signed overflow.
// Shared by ADD and SUB; for SUB the caller presents ~b so that a + ~b + cin
// yields a - b - (1 - cin).
module alu_adder8 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   // carry_chain[i] is the carry into bit i; carry_chain[WIDTH] leaves the MSB
   logic [WIDTH:0] carry_chain;

   assign carry_chain[0] = carry_in;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign sum[gi]             = a[gi] ^ b[gi] ^ carry_chain[gi];
         assign carry_chain[gi + 1] = (a[gi] & b[gi]) |
                                      (carry_chain[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign carry_out = carry_chain[WIDTH];

   // Signed overflow: carry into the sign bit differs from carry out of it.
   // Equivalent to "operands share a sign and the sum's sign differs".
   assign overflow = carry_chain[WIDTH] ^ carry_chain[WIDTH-1];

endmodule

// File: rtl/nes_alu.sv
// 8-bit ALU for the 2A03 CPU datapath (binary only, no decimal mode).
// Mode mux and flag logic feed a single output register: one cycle latency,
// a new operation may be issued every cycle.
module nes_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] alu_a,
   input  logic [WIDTH-1:0] alu_b,
   input  alu_mode_t        mode,
   input  logic             carry_in,
   output logic [WIDTH-1:0] alu_out,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             sign
);

   // Adder operand B: inverted for SUB so carry_in acts as "no borrow"
   logic [WIDTH-1:0] adder_b;
   logic [WIDTH-1:0] adder_sum;
   logic             adder_carry;
   logic             adder_ovf;

   assign adder_b = alu_is_sub(mode) ? ~alu_b : alu_b;

   alu_adder8 #(
      .WIDTH(WIDTH)
   ) u_adder (
      .a        (alu_a),
      .b        (adder_b),
      .carry_in (carry_in),
      .sum      (adder_sum),
      .carry_out(adder_carry),
      .overflow (adder_ovf)
   );

   logic [WIDTH-1:0] result_next;
   logic             carry_next;
   logic             overflow_next;
   logic             zero_next;
   logic             sign_next;

   logic [WIDTH-1:0] result_reg;
   logic             carry_reg;
   logic             overflow_reg;
   logic             zero_reg;
   logic             sign_reg;

   // Mode mux: unassigned codes (6..31) fall through to the ADD defaults
   always_comb begin
      result_next   = adder_sum;
      carry_next    = adder_carry;
      overflow_next = adder_ovf;
      case (mode)
         ALU_AND: begin
            result_next   = alu_a & alu_b;
            carry_next    = 1'b0;
            overflow_next = 1'b0;
         end
         ALU_OR: begin
            result_next   = alu_a | alu_b;
            carry_next    = 1'b0;
            overflow_next = 1'b0;
         end
         ALU_EOR: begin
            result_next   = alu_a ^ alu_b;
            carry_next    = 1'b0;
            overflow_next = 1'b0;
         end
         ALU_SR: begin
            // carry_in fills the vacated MSB; the shifted-out LSB becomes C
            result_next   = {carry_in, alu_a[WIDTH-1:1]};
            carry_next    = alu_a[0];
            overflow_next = 1'b0;
         end
         default: begin
            // ADD, SUB and every unused code take the adder result as-is
            result_next   = adder_sum;
            carry_next    = adder_carry;
            overflow_next = adder_ovf;
         end
      endcase
      zero_next = (result_next == '0);
      sign_next = result_next[WIDTH-1];
   end

   // Output register; reset clears all outputs without waiting for a clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_reg   <= '0;
         carry_reg    <= 1'b0;
         overflow_reg <= 1'b0;
         zero_reg     <= 1'b0;
         sign_reg     <= 1'b0;
      end else begin
         result_reg   <= result_next;
         carry_reg    <= carry_next;
         overflow_reg <= overflow_next;
         zero_reg     <= zero_next;
         sign_reg     <= sign_next;
      end
   end

   assign alu_out   = result_reg;
   assign carry_out = carry_reg;
   assign overflow  = overflow_reg;
   assign zero      = zero_reg;
   assign sign      = sign_reg;

endmodule

// File: tb/tb_nes_alu.sv
// Self-checking bench for nes_alu: directed vectors from the datasheet cases,
// asynchronous reset behaviour, output hold, and randomized back-to-back traffic
// checked against an integer-arithmetic reference model.
module tb_nes_alu;
   import alu_pkg::*;

   logic       clk;
   logic       rst;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [4:0] mode;
   logic       carry_in;
   logic [7:0] alu_out;
   logic       carry_out;
   logic       overflow;
   logic       zero;
   logic       sign;

   int compared   = 0;
   int mismatched = 0;

   nes_alu #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .mode     (mode),
      .carry_in (carry_in),
      .alu_out  (alu_out),
      .carry_out(carry_out),
      .overflow (overflow),
      .zero     (zero),
      .sign     (sign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed observation: {result, C, V, Z, N}
   function automatic logic [11:0] observed();
      return {alu_out, carry_out, overflow, zero, sign};
   endfunction

   // Reference model from the arithmetic definition of each operation
   function automatic int sx(input int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   function automatic logic [11:0] model(input int a, input int b, input int m, input int cin);
      int s, sv, r;
      logic c, v;
      c = 1'b0;
      v = 1'b0;
      case (m)
         1: r = a & b;
         2: r = a | b;
         3: r = a ^ b;
         4: begin
            r = cin * 128 + a / 2;
            c = (a % 2) == 1;
         end
         5: begin
            s  = a + (255 - b) + cin;
            r  = s % 256;
            c  = s > 255;
            sv = sx(a) - sx(b) - (1 - cin);
            v  = (sv > 127) || (sv < -128);
         end
         default: begin
            s  = a + b + cin;
            r  = s % 256;
            c  = s > 255;
            sv = sx(a) + sx(b) + cin;
            v  = (sv > 127) || (sv < -128);
         end
      endcase
      return {r[7:0], c, v, (r == 0), (r >= 128)};
   endfunction

   // Drive one operation away from the active edge and sample just after it
   task automatic issue(input logic [7:0] a, input logic [7:0] b,
                        input logic [4:0] m, input logic cin);
      @(negedge clk);
      alu_a    = a;
      alu_b    = b;
      mode     = m;
      carry_in = cin;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [11:0] got;
      repeat (2) @(posedge clk);
      #1;
      got = observed();
      compared++;
      if (got !== 12'h000) begin
         mismatched++;
         $display("FAIL reset_held: got %h, required 000", got);
      end else $display("reset_held: outputs %h", got);
      @(negedge clk);
      rst = 1'b0;
      #1;
      got = observed();
      compared++;
      if (got !== 12'h000) begin
         mismatched++;
         $display("FAIL reset_release_before_edge: got %h, required 000", got);
      end else $display("reset_release_before_edge: outputs %h", got);
   endtask

   task automatic run_table(input string name, input logic [33:0] vec [], input int n);
      logic [7:0]  a, b;
      logic [4:0]  m;
      logic        c;
      logic [11:0] e, got;
      for (int i = 0; i < n; i++) begin
         {a, b, m, c, e} = vec[i];
         issue(a, b, m, c);
         got = observed();
         compared++;
         if (got !== e) begin
            mismatched++;
            $display("FAIL %s[%0d] mode=%0d a=%h b=%h cin=%b: got out=%h cvzn=%b, required out=%h cvzn=%b",
                     name, i, m, a, b, c, got[11:4], got[3:0], e[11:4], e[3:0]);
         end else
            $display("%s[%0d] mode=%0d a=%h b=%h cin=%b -> out=%h cvzn=%b",
                     name, i, m, a, b, c, got[11:4], got[3:0]);
      end
   endtask

   task automatic test_add();
      logic [33:0] vec [];
      vec = new[3];
      vec[0] = {8'h50, 8'h50, ALU_ADD, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1};
      vec[1] = {8'hFF, 8'h01, ALU_ADD, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
      vec[2] = {8'hFF, 8'h01, ALU_ADD, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
      run_table("add", vec, 3);
   endtask

   task automatic test_sub();
      logic [33:0] vec [];
      vec = new[4];
      vec[0] = {8'h50, 8'hB0, ALU_SUB, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1};
      vec[1] = {8'h05, 8'h03, ALU_SUB, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
      vec[2] = {8'h00, 8'h01, ALU_SUB, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
      vec[3] = {8'h05, 8'h03, ALU_SUB, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
      run_table("sub", vec, 4);
   endtask

   task automatic test_logic();
      logic [33:0] vec [];
      vec = new[3];
      vec[0] = {8'hF0, 8'h0F, ALU_AND, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      vec[1] = {8'hF0, 8'h0F, ALU_OR,  1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
      vec[2] = {8'hF0, 8'hF0, ALU_EOR, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      run_table("logic", vec, 3);
   endtask

   task automatic test_sr();
      logic [33:0] vec [];
      vec = new[2];
      vec[0] = {8'h81, 8'hFF, ALU_SR, 1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1};
      vec[1] = {8'h01, 8'h5A, ALU_SR, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
      run_table("sr", vec, 2);
   endtask

   task automatic test_unused_modes();
      logic [33:0] vec [];
      vec = new[3];
      vec[0] = {8'h10, 8'h20, 5'd7,  1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
      vec[1] = {8'hFF, 8'h01, 5'd31, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
      vec[2] = {8'h7F, 8'h01, 5'd6,  1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
      run_table("unused_mode", vec, 3);
   endtask

   task automatic test_async_reset();
      logic [11:0] got;
      issue(8'h50, 8'h50, ALU_ADD, 1'b0);
      got = observed();
      compared++;
      if (got !== 12'hA05) begin
         mismatched++;
         $display("FAIL areset_pre_add: got %h, required a05", got);
      end else $display("areset_pre_add: outputs %h", got);
      #2;
      rst      = 1'b1;
      alu_a    = 8'h10;
      alu_b    = 8'h20;
      mode     = 5'd7;
      carry_in = 1'b0;
      #1;
      got = observed();
      compared++;
      if (got !== 12'h000) begin
         mismatched++;
         $display("FAIL areset_immediate: got %h, required 000", got);
      end else $display("areset_immediate: outputs %h", got);
      @(posedge clk);
      #1;
      got = observed();
      compared++;
      if (got !== 12'h000) begin
         mismatched++;
         $display("FAIL areset_hold_over_edge: got %h, required 000", got);
      end else $display("areset_hold_over_edge: outputs %h", got);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      got = observed();
      compared++;
      if (got !== 12'h000) begin
         mismatched++;
         $display("FAIL areset_release_midcycle: got %h, required 000", got);
      end else $display("areset_release_midcycle: outputs %h", got);
      @(posedge clk);
      #1;
      got = observed();
      compared++;
      if (got !== 12'h300) begin
         mismatched++;
         $display("FAIL areset_first_edge: got %h, required 300", got);
      end else $display("areset_first_edge: outputs %h", got);
   endtask

   task automatic test_hold();
      logic [11:0] got, e;
      issue(8'h80, 8'h80, ALU_ADD, 1'b0);
      e = model(128, 128, 0, 0);
      @(negedge clk);
      alu_a    = 8'h01;
      alu_b    = 8'h02;
      mode     = ALU_OR;
      carry_in = 1'b1;
      #1;
      got = observed();
      compared++;
      if (got !== e) begin
         mismatched++;
         $display("FAIL hold_between_edges: got %h, required %h", got, e);
      end else $display("hold_between_edges: outputs %h", got);
   endtask

   task automatic test_back_to_back();
      logic [7:0]  a, b;
      logic [4:0]  m;
      logic        c;
      logic [11:0] e, got;
      for (int i = 0; i < 200; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         c = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) m = 5'($urandom_range(6, 31));
         else                           m = 5'($urandom_range(0, 5));
         issue(a, b, m, c);
         e   = model(int'(a), int'(b), int'(m), int'(c));
         got = observed();
         compared++;
         if (got !== e) begin
            mismatched++;
            $display("FAIL rand[%0d] mode=%0d a=%h b=%h cin=%b: got out=%h cvzn=%b, required out=%h cvzn=%b",
                     i, m, a, b, c, got[11:4], got[3:0], e[11:4], e[3:0]);
         end else
            $display("rand[%0d] mode=%0d a=%h b=%h cin=%b -> out=%h cvzn=%b",
                     i, m, a, b, c, got[11:4], got[3:0]);
      end
   endtask

   initial begin
      rst      = 1'b1;
      alu_a    = 8'h00;
      alu_b    = 8'h00;
      mode     = ALU_ADD;
      carry_in = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_sr();
      test_unused_modes();
      test_async_reset();
      test_hold();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Watchdog: the sequence is purely clock-driven, so this only trips on a hang
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
